// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Elastic pipeline register with a 2-entry skid buffer. Sits between two CPU
//   pipeline stages. The payload is opaque, e.g. {instr, PC} at F->D.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low
//   in_valid   upstream offers in_data
//   in_ready   stage can accept (inverse of the skid valid flop)
//   in_data    upstream payload
//   flush      drop every held entry
//   out_valid  out_data carries a real entry
//   out_ready  downstream accepts this cycle
//   out_data   head payload, or NOP_VAL when empty
//   occupancy  held entries, 0..2
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
module pipe_skid_stage #(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_d, skid_d;
    logic              main_v_nxt, skid_v_nxt;
    logic              ld_main_in, ld_main_skid, ld_skid;
    logic              in_fire, out_fire;

    // in_ready depends only on the skid flop, so out_ready never reaches it
    // combinationally.
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_v ? main_d : NOP_VAL;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        main_v_nxt   = main_v;
        skid_v_nxt   = skid_v;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            main_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
        end else if (!main_v) begin
            // skid is never full while main is empty
            if (in_fire) begin
                main_v_nxt = 1'b1;
                ld_main_in = 1'b1;
            end
        end else if (out_fire) begin
            if (skid_v) begin
                // in_ready was low, so no new entry can arrive this cycle
                ld_main_skid = 1'b1;
                skid_v_nxt   = 1'b0;
            end else if (in_fire) begin
                ld_main_in = 1'b1;
            end else begin
                main_v_nxt = 1'b0;
            end
        end else if (in_fire) begin
            ld_skid    = 1'b1;
            skid_v_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            main_v <= main_v_nxt;
            skid_v <= skid_v_nxt;
        end
    end

    // Payload registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (ld_main_in)
            main_d <= in_data;
        else if (ld_main_skid)
            main_d <= skid_d;
        if (ld_skid)
            skid_d <= in_data;
    end

    // Not cleared by flush so stall history survives mispredicts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNT_ONE;
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

    localparam int         DW  = 8;
    localparam logic [7:0] NOP = 8'h5A;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    // second instance with a narrow counter for the saturation test
    logic          s_in_valid = 1'b0, s_flush = 1'b0, s_out_ready = 1'b0;
    logic [DW-1:0] s_in_data = '0;
    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occupancy;
    logic [2:0]    s_stall_cnt;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(3)) s_dut (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .flush(s_flush), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .occupancy(s_occupancy),
        .stall_cnt(s_stall_cnt)
    );

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] out_log[$];
    int            scnt = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: the queue holds entries accepted but not yet consumed, so its
    // size is the expected occupancy and its head the expected out_data.
    always @(negedge clk) begin
        int n;
        if (!reset) begin
            sb_q.delete();
            scnt = 0;
        end else if (mon_en) begin
            n = sb_q.size();
            chk("out_valid", int'(out_valid), int'(n > 0));
            chk("occupancy", int'(occupancy), n);
            chk("in_ready", int'(in_ready), int'(n < 2));
            chk("stall_cnt", int'(stall_cnt), scnt);
            if (n > 0) chk("out_data", int'(out_data), int'(sb_q[0]));
            else       chk("out_data_nop", int'(out_data), int'(NOP));
            if (n > 0 && !out_ready && scnt < 65535) scnt++;
            if (flush) begin
                sb_q.delete();
            end else begin
                if (n > 0 && out_ready) out_log.push_back(sb_q.pop_front());
                if (in_valid && n < 2) sb_q.push_back(in_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry and hold it until accepted, with a bounded wait.
    task automatic send(input logic [DW-1:0] d);
        int tries = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && tries < 20) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            tries++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, before any clock edge
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), int'(NOP));
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // streaming at full rate
        out_log.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("stream_count", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("stream_seq", int'(out_log[i]), 16 + i);

        // back-pressure
        out_log.delete();
        out_ready = 1'b0;
        send(8'hA1);
        send(8'hA2);
        in_valid = 1'b1;
        in_data  = 8'hA3;
        cyc();
        @(negedge clk);
        chk("bp_occupancy", int'(occupancy), 2);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_head", int'(out_data), 8'hA1);
        chk("bp_none_out", out_log.size(), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'hA3);
        repeat (4) cyc();
        chk("bp_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("bp_seq0", int'(out_log[0]), 8'hA1);
            chk("bp_seq1", int'(out_log[1]), 8'hA2);
            chk("bp_seq2", int'(out_log[2]), 8'hA3);
        end

        // flush with two held entries while 0xB0 is offered
        out_log.delete();
        out_ready = 1'b0;
        send(8'hC1);
        send(8'hC2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hB0;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_occupancy", int'(occupancy), 0);
        chk("fl_out_valid", int'(out_valid), 0);
        chk("fl_out_data", int'(out_data), int'(NOP));
        chk("fl_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("fl_nothing_out", out_log.size(), 0);

        // asynchronous reset mid-cycle with two entries and a nonzero counter
        out_ready = 1'b0;
        send(8'hD1);
        send(8'hD2);
        cyc();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_out_data", int'(out_data), int'(NOP));
        chk("mrst_in_ready", int'(in_ready), 1);
        chk("mrst_occupancy", int'(occupancy), 0);
        chk("mrst_stall_cnt", int'(stall_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // counter saturation on the CNT_W=3 instance
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 8'h77;
        cyc();
        s_in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("sat_cnt", int'(s_stall_cnt), (k > 7) ? 7 : k);
        end
        s_flush = 1'b1;
        cyc();
        s_flush = 1'b0;
        cyc();
        chk("sat_after_flush", int'(s_stall_cnt), 7);
        chk("sat_out_valid", int'(s_out_valid), 0);
        chk("sat_out_data", int'(s_out_data), int'(NOP));

        // random traffic, checked by the scoreboard
        out_log.delete();
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rnd_occ_le2", int'(occupancy <= 2'd2), 1);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("rnd_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
